// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_responder
// Brief    : SPI slave emulating an 8-channel 12-bit SAR ADC. Synchronises
//            the master's CONVST/SCK/SDI into clk, runs the conversion and
//            shift sequence, and fetches samples from fabric through a
//            sample_req / sample_valid handshake.
//            Optional build macro ADC_RESP_TEST_PATTERN_EN replaces the
//            handshake with an internally generated {channel, frame count}
//            test pattern.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_responder #(
    parameter int DATA_W      = 12,
    parameter int CFG_W       = 6,
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CONVST,
    input  logic              spi_scl,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              sample_req,
    output logic [2:0]        sample_ch,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic [CFG_W-1:0]  cfg_word,
    output logic              cfg_valid,
    output logic              busy,
    output logic              err_nodata
);

    localparam int c_CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int c_FALL_W = $clog2(DATA_W + 1);
    localparam int c_RISE_W = $clog2(CFG_W + 1);

    localparam logic [c_CONV_W-1:0] c_CONV_LOAD = c_CONV_W'(CONV_CYCLES - 1);
    localparam logic [c_FALL_W-1:0] c_LAST_FALL = c_FALL_W'(DATA_W - 1);
    localparam logic [c_RISE_W-1:0] c_CFG_FULL  = c_RISE_W'(CFG_W);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_CONVERT  = 2'd1;
    localparam logic [1:0] c_S_WAIT_LOW = 2'd2;
    localparam logic [1:0] c_S_SHIFT    = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronisers and edge-detect history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_convst_sync;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_convst_hist;
    logic                   r_scl_hist;

    // Bring the asynchronous SPI pins into clk and keep one history flop for edges
    always_ff @(posedge clk) begin
        if (reset) begin
            r_convst_sync <= '0;
            r_scl_sync    <= '0;
            r_sdi_sync    <= '0;
            r_convst_hist <= 1'b0;
            r_scl_hist    <= 1'b0;
        end else begin
            r_convst_sync <= {r_convst_sync[SYNC_STAGES-2:0], CONVST};
            r_scl_sync    <= {r_scl_sync[SYNC_STAGES-2:0], spi_scl};
            r_sdi_sync    <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            r_convst_hist <= r_convst_sync[SYNC_STAGES-1];
            r_scl_hist    <= r_scl_sync[SYNC_STAGES-1];
        end
    end

    logic w_convst_s;
    logic w_sdi_s;
    logic w_convst_rise;
    logic w_scl_rise;
    logic w_scl_fall;

    assign w_convst_s    = r_convst_sync[SYNC_STAGES-1];
    assign w_sdi_s       = r_sdi_sync[SYNC_STAGES-1];
    assign w_convst_rise = w_convst_s & ~r_convst_hist;
    assign w_scl_rise    = r_scl_sync[SYNC_STAGES-1] & ~r_scl_hist;
    assign w_scl_fall    = ~r_scl_sync[SYNC_STAGES-1] & r_scl_hist;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_busy;

    logic                r_sdo;
    logic                r_req;
    logic [2:0]          r_ch;
    logic [2:0]          r_ptr;
    logic [CFG_W-1:0]    r_cfg;
    logic                r_cfg_valid;
    logic                r_err;
    logic [c_CONV_W-1:0] r_conv_cnt;
    logic                r_captured;
    logic [DATA_W-1:0]   r_sh;
    logic [CFG_W-1:0]    r_cfg_sh;
    logic [c_RISE_W-1:0] r_rise_cnt;
    logic [c_FALL_W-1:0] r_fall_cnt;

    logic                w_cfg_done;
    logic                w_start;
    logic                w_abort_latch;
    logic                w_frame_end;
    logic                w_cfg_latch;
    logic [2:0]          w_next_ch;

    assign w_cfg_done    = (r_rise_cnt == c_CFG_FULL);
    // A CONVST rise is only honoured when no conversion is in flight; it also
    // beats any SCK edge decoded in the same cycle.
    assign w_start       = w_convst_rise &&
                           ((r_state == c_S_IDLE) || (r_state == c_S_SHIFT));
    assign w_abort_latch = w_convst_rise && (r_state == c_S_SHIFT) && w_cfg_done;
    assign w_frame_end   = (r_state == c_S_SHIFT) && !w_convst_rise &&
                           w_scl_fall && (r_fall_cnt == c_LAST_FALL);
    assign w_cfg_latch   = w_abort_latch || (w_frame_end && w_cfg_done);
    // A short frame that still delivered a full config selects the channel of
    // the conversion it starts, keeping the one-frame config pipeline intact.
    assign w_next_ch     = w_abort_latch ? r_cfg_sh[CFG_W-2 -: 3] : r_ptr;

`ifdef ADC_RESP_TEST_PATTERN_EN
    logic [DATA_W-4:0] r_frame_cnt;
    logic              w_unused_tp;
    assign w_unused_tp = ^{sample_data, sample_valid};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_start) w_state_nxt = c_S_CONVERT;
            end
            c_S_CONVERT: begin
                if (r_conv_cnt == '0) w_state_nxt = c_S_WAIT_LOW;
            end
            c_S_WAIT_LOW: begin
                if (!w_convst_s) w_state_nxt = c_S_SHIFT;
            end
            c_S_SHIFT: begin
                if (w_start) begin
                    w_state_nxt = c_S_CONVERT;
                end else if (w_frame_end) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_busy = 1'b0;
        if (r_state == c_S_CONVERT) w_busy = 1'b1;
    end

    // Conversion, sample capture, bit shifting and config latching
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sdo       <= 1'b0;
            r_req       <= 1'b0;
            r_ch        <= 3'd0;
            r_ptr       <= 3'd0;
            r_cfg       <= '0;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
            r_conv_cnt  <= '0;
            r_captured  <= 1'b0;
            r_sh        <= '0;
            r_cfg_sh    <= '0;
            r_rise_cnt  <= '0;
            r_fall_cnt  <= '0;
`ifdef ADC_RESP_TEST_PATTERN_EN
            r_frame_cnt <= '0;
`else
`endif
        end else begin
            r_req       <= 1'b0;
            r_cfg_valid <= 1'b0;

            if (w_cfg_latch) begin
                r_cfg       <= r_cfg_sh;
                r_ptr       <= r_cfg_sh[CFG_W-2 -: 3];
                r_cfg_valid <= 1'b1;
            end

            if (w_start) begin
                r_sdo      <= 1'b0;
                r_ch       <= w_next_ch;
                r_conv_cnt <= c_CONV_LOAD;
                r_captured <= 1'b0;
`ifdef ADC_RESP_TEST_PATTERN_EN
                r_sh        <= {w_next_ch, r_frame_cnt};
                r_frame_cnt <= r_frame_cnt + 1'b1;
`else
                r_req      <= 1'b1;
`endif
            end else begin
                case (r_state)
                    c_S_CONVERT: begin
                        if (r_conv_cnt != '0) r_conv_cnt <= r_conv_cnt - 1'b1;
`ifdef ADC_RESP_TEST_PATTERN_EN
`else
                        // Only the first sample_valid of a conversion counts
                        if (sample_valid && !r_captured) begin
                            r_sh       <= sample_data;
                            r_captured <= 1'b1;
                        end else if ((r_conv_cnt == '0) && !r_captured) begin
                            r_sh  <= '0;
                            r_err <= 1'b1;
                        end
`endif
                    end
                    c_S_WAIT_LOW: begin
                        if (!w_convst_s) begin
                            r_sdo      <= r_sh[DATA_W-1];
                            r_rise_cnt <= '0;
                            r_fall_cnt <= '0;
                            r_cfg_sh   <= '0;
                        end
                    end
                    c_S_SHIFT: begin
                        if (w_scl_rise && !w_cfg_done) begin
                            r_cfg_sh   <= {r_cfg_sh[CFG_W-2:0], w_sdi_s};
                            r_rise_cnt <= r_rise_cnt + 1'b1;
                        end
                        if (w_scl_fall) begin
                            if (r_fall_cnt == c_LAST_FALL) begin
                                r_sdo <= 1'b0;
                            end else begin
                                r_sh  <= {r_sh[DATA_W-2:0], 1'b0};
                                r_sdo <= r_sh[DATA_W-2];
                            end
                            r_fall_cnt <= r_fall_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_sdo    = r_sdo;
    assign sample_req = r_req;
    assign sample_ch  = r_ch;
    assign cfg_word   = r_cfg;
    assign cfg_valid  = r_cfg_valid;
    assign busy       = w_busy;
    assign err_nodata = r_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_adc_spi_responder
// Brief    : Self-checking bench for adc_spi_responder. Plays the SPI master
//            and the sample-supplying fabric; expected read data, channel,
//            config and error flag come from a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_responder;

    localparam int DATA_W      = 12;
    localparam int CFG_W       = 6;
    localparam int CONV_CYCLES = 80;
`ifdef ADC_RESP_TEST_PATTERN_EN
    localparam int c_EXP_REQ = 0;
`else
    localparam int c_EXP_REQ = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              CONVST;
    logic              spi_scl;
    logic              spi_sdi;
    logic              spi_sdo;
    logic              sample_req;
    logic [2:0]        sample_ch;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic [CFG_W-1:0]  cfg_word;
    logic              cfg_valid;
    logic              busy;
    logic              err_nodata;

    always #5 clk = ~clk;

    adc_spi_responder #(
        .DATA_W      (DATA_W),
        .CFG_W       (CFG_W),
        .CONV_CYCLES (CONV_CYCLES),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .CONVST       (CONVST),
        .spi_scl      (spi_scl),
        .spi_sdi      (spi_sdi),
        .spi_sdo      (spi_sdo),
        .sample_req   (sample_req),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .cfg_word     (cfg_word),
        .cfg_valid    (cfg_valid),
        .busy         (busy),
        .err_nodata   (err_nodata)
    );

    int checks = 0;
    int errors = 0;

    // Running totals of pulse/level activity, sampled away from the active edge
    int req_total  = 0;
    int busy_total = 0;
    int cfgv_total = 0;
    always @(negedge clk) begin
        if (sample_req) req_total++;
        if (busy)       busy_total++;
        if (cfg_valid)  cfgv_total++;
    end

    // Frame-level model of the converter
    logic [2:0]        m_ptr;
    logic [CFG_W-1:0]  m_cfg;
    logic              m_err;
    int unsigned       m_frames;
    logic [DATA_W-1:0] m_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a conversion, act as fabric during it, and check the busy window
    task automatic do_conv(input bit provide, input logic [DATA_W-1:0] data,
                           input int delay, input bit glitch, input bit check_ch);
        int  b0;
        int  r0;
        bit  seen;
        bit  done;
        logic [2:0] exp_ch;
        exp_ch = m_ptr;
`ifdef ADC_RESP_TEST_PATTERN_EN
        m_exp = {exp_ch, m_frames[DATA_W-4:0]};
`else
        m_exp = provide ? data : '0;
        if (!provide) m_err = 1'b1;
`endif
        m_frames++;
        b0 = busy_total;
        r0 = req_total;
        @(negedge clk);
        CONVST = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("conv_start", 32'(seen), 1);
        done = 1'b0;
        for (int c = 0; c < 200 && seen; c++) begin
            sample_data  = (c == delay) ? data : ~data;
            sample_valid = provide && ((c == delay) || (c == delay + 6));
            if (glitch && c == 5)  CONVST = 1'b0;
            if (glitch && c == 40) CONVST = 1'b1;
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        sample_valid = 1'b0;
        CONVST       = 1'b0;
        chk("conv_end", 32'(done), 1);
        chk("busy_cycles", 32'(busy_total - b0), CONV_CYCLES);
        chk("req_pulses", 32'(req_total - r0), c_EXP_REQ);
        if (check_ch) chk("sample_ch", 32'(sample_ch), 32'(exp_ch));
    endtask

    // Clock nbits SCK periods as the master, collecting the first DATA_W bits
    task automatic do_shift(input logic [CFG_W-1:0] cfg, input int nbits,
                            output logic [DATA_W-1:0] rd);
        rd = '0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            spi_sdi = (b < CFG_W) ? cfg[CFG_W-1-b] : 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            if (b < DATA_W) rd = {rd[DATA_W-2:0], spi_sdo};
            spi_scl = 1'b1;
            repeat (4) @(negedge clk);
            spi_scl = 1'b0;
        end
        repeat (6) @(negedge clk);
        spi_sdi = 1'b0;
    endtask

    // Complete shift phase of a frame plus its end-of-frame checks
    task automatic tail_full(input logic [CFG_W-1:0] cfg, input int nbits);
        int v0;
        logic [DATA_W-1:0] rd;
        v0 = cfgv_total;
        do_shift(cfg, nbits, rd);
        m_cfg = cfg;
        m_ptr = cfg[4:2];
        chk("read_data", 32'(rd), 32'(m_exp));
        chk("cfg_valid_pulses", 32'(cfgv_total - v0), 1);
        chk("cfg_word", 32'(cfg_word), 32'(m_cfg));
        chk("err_nodata", 32'(err_nodata), 32'(m_err));
        chk("sdo_idle", 32'(spi_sdo), 0);
    endtask

    task automatic frame(input logic [CFG_W-1:0] cfg, input bit provide,
                         input logic [DATA_W-1:0] data, input int delay, input int nbits);
        do_conv(provide, data, delay, 1'b0, 1'b1);
        tail_full(cfg, nbits);
    endtask

    // Short frame cut by a fresh CONVST after nbits SCK periods
    task automatic tail_abort(input logic [CFG_W-1:0] cfg, input int nbits,
                              input logic [DATA_W-1:0] next_data);
        int v0;
        logic [DATA_W-1:0] rd;
        v0 = cfgv_total;
        do_shift(cfg, nbits, rd);
        if (nbits >= CFG_W) begin
            m_cfg = cfg;
            m_ptr = cfg[4:2];
        end
        do_conv(1'b1, next_data, 4, 1'b0, nbits < CFG_W);
        chk("abort_cfg_valid", 32'(cfgv_total - v0), (nbits >= CFG_W) ? 1 : 0);
        chk("abort_cfg_word", 32'(cfg_word), 32'(m_cfg));
    endtask

    initial begin
        reset        = 1'b1;
        CONVST       = 1'b0;
        spi_scl      = 1'b0;
        spi_sdi      = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        m_ptr        = 3'd0;
        m_cfg        = '0;
        m_err        = 1'b0;
        m_frames     = 0;
        repeat (5) @(negedge clk);
        chk("rst_sdo", 32'(spi_sdo), 0);
        chk("rst_req", 32'(sample_req), 0);
        chk("rst_ch", 32'(sample_ch), 0);
        chk("rst_cfg", 32'(cfg_word), 0);
        chk("rst_cfg_valid", 32'(cfg_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_nodata), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Basic frame, then config pipelining into the following frames
        frame(6'b100010, 1'b1, 12'hA5C, 3, 12);
        frame(6'b110100, 1'b1, 12'h7E1, 10, 12);
        frame(6'b000000, 1'b1, 12'h123, 3, 12);

        // Missing sample: zero data and a sticky error through good frames
        frame(6'b011100, 1'b0, 12'h000, 0, 12);
        frame(6'b001000, 1'b1, 12'hFFF, 20, 12);

        // Short frames: too short to latch config, then long enough
        do_conv(1'b1, 12'h5A5, 7, 1'b0, 1'b1);
        tail_abort(6'b110000, 4, 12'h3C3);
        tail_abort(6'b101100, 8, 12'h9E7);
        tail_full(6'b010100, 12);

        // Re-pulsed CONVST inside the conversion window is ignored
        do_conv(1'b1, 12'h246, 30, 1'b1, 1'b1);
        tail_full(6'b100100, 12);

        // Extra SCK periods beyond the sample width
        frame(6'b111000, 1'b1, 12'h8C1, 12, 14);

        // Randomised frames
        for (int i = 0; i < 6; i++) begin
            frame(6'($urandom), ($urandom_range(0, 3) != 0),
                  12'($urandom), int'($urandom_range(0, 60)), 12);
        end

        // Reset in the middle of a conversion
        @(negedge clk);
        CONVST = 1'b1;
        repeat (25) @(negedge clk);
        reset  = 1'b1;
        CONVST = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cfg", 32'(cfg_word), 0);
        chk("midrst_ch", 32'(sample_ch), 0);
        chk("midrst_err", 32'(err_nodata), 0);
        chk("midrst_sdo", 32'(spi_sdo), 0);
        reset    = 1'b0;
        m_ptr    = 3'd0;
        m_cfg    = '0;
        m_err    = 1'b0;
        m_frames = 0;
        repeat (3) @(negedge clk);
        frame(6'b100010, 1'b1, 12'h3E9, 5, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
